// File: rtl/mux_rr_sel.sv
// rtl/mux_rr_sel.sv - round-robin select sequencer for a 4:1 mux (optional grant lock: MUX_RR_LOCK_EN)
module mux_rr_sel #(
    parameter logic [1:0] START_PTR = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ready,
`ifdef MUX_RR_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       valid,
    output logic [3:0] ack
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic [1:0] ptr_q, ptr_d;

    logic [1:0] win;
    logic       found;
    logic       hold_lock;

    // Winner: first requesting channel scanning ptr, ptr+1, ... modulo 4.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr_q + 2'(i)]) begin
                win   = ptr_q + 2'(i);
                found = 1'b1;
            end
        end
    end

    // A locked handshake keeps the current channel granted with no bubble.
    always_comb begin
        hold_lock = 1'b0;
`ifdef MUX_RR_LOCK_EN
        hold_lock = lock & req[sel_q];
`endif
    end

    // Next-state: grant on request, release on handshake or withdrawal, hold while stalled.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = win;
                    gnt_d   = 4'(1) << win;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (ready) begin
                    // Transfer completes; ready wins over a same-cycle withdrawal.
                    if (!hold_lock) begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                        ptr_d   = sel_q + 2'd1;
                    end
                end else if (!req[sel_q]) begin
                    // Abandoned grant: no ack and the pointer stays put.
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset acts immediately, even mid-transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            ptr_q   <= START_PTR;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel   = sel_q;
    assign gnt   = gnt_q;
    assign valid = valid_q;
    assign ack   = gnt_q & {4{ready}};

endmodule

// File: tb/tb_mux_rr_sel.sv
// tb/tb_mux_rr_sel.sv - directed self-checking bench for mux_rr_sel
module tb_mux_rr_sel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       ready;
    logic       lock;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
    logic [3:0] ack;

    int checks = 0;
    int errors = 0;

    mux_rr_sel #(.START_PTR(2'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ready (ready),
`ifdef MUX_RR_LOCK_EN
        .lock  (lock),
`endif
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid),
        .ack   (ack)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then driven away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        lock  = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        lock  = 1'b0;
        step();
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
        rst_n = 1'b1;
        req   = 4'b0100;
        step();
        checks++; if (sel !== 2'd2 || gnt !== 4'b0100 || valid !== 1'b1) begin
            errors++; $display("FAIL reset_pre_grant got sel=%0d gnt=%b valid=%b want 2 0100 1", sel, gnt, valid);
        end
        ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (sel !== 2'd0 || gnt !== 4'b0000 || valid !== 1'b0 || ack !== 4'b0000) begin
            errors++; $display("FAIL reset_async got sel=%0d gnt=%b valid=%b ack=%b want 0 0000 0 0000", sel, gnt, valid, ack);
        end
        ready = 1'b0;
        req   = 4'b1111;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (sel !== 2'd0 || gnt !== 4'b0001 || valid !== 1'b1) begin
            errors++; $display("FAIL reset_first_grant got sel=%0d gnt=%b valid=%b want 0 0001 1", sel, gnt, valid);
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_sel [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req   = 4'b1111;
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (valid !== 1'b1 || sel !== exp_sel[k]) begin
                errors++; $display("FAIL rot_grant%0d got valid=%b sel=%0d want 1 %0d", k, valid, sel, exp_sel[k]);
            end
            checks++; if (ack !== (4'b0001 << exp_sel[k])) begin
                errors++; $display("FAIL rot_ack%0d got %b want %b", k, ack, 4'b0001 << exp_sel[k]);
            end
            step();
            checks++; if (valid !== 1'b0 || ack !== 4'b0000 || sel !== exp_sel[k]) begin
                errors++; $display("FAIL rot_bubble%0d got valid=%b ack=%b sel=%0d want 0 0000 %0d", k, valid, ack, sel, exp_sel[k]);
            end
        end
    endtask

    task automatic test_skip_wrap();
        do_reset();
        req   = 4'b0100;
        ready = 1'b1;
        step();
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL skip_setup got sel=%0d want 2", sel); end
        req = 4'b0101;
        step();
        step();
        checks++; if (sel !== 2'd0 || gnt !== 4'b0001) begin
            errors++; $display("FAIL skip_wrap got sel=%0d gnt=%b want 0 0001", sel, gnt);
        end
        step();
        step();
        checks++; if (sel !== 2'd2 || gnt !== 4'b0100) begin
            errors++; $display("FAIL skip_next got sel=%0d gnt=%b want 2 0100", sel, gnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        req   = 4'b0010;
        ready = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) req = 4'b1011;
            if (k == 3) req = 4'b0110;
            #1;
            checks++; if (sel !== 2'd1 || gnt !== 4'b0010 || valid !== 1'b1 || ack !== 4'b0000) begin
                errors++; $display("FAIL stall%0d got sel=%0d gnt=%b valid=%b ack=%b want 1 0010 1 0000", k, sel, gnt, valid, ack);
            end
            step();
        end
        ready = 1'b1;
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL stall_ack got %b want 0010", ack); end
        req = 4'b0000;
        step();
        checks++; if (valid !== 1'b0 || ack !== 4'b0000) begin
            errors++; $display("FAIL stall_release got valid=%b ack=%b want 0 0000", valid, ack);
        end
    endtask

    task automatic test_withdrawal();
        do_reset();
        req   = 4'b0100;
        ready = 1'b0;
        step();
        req = 4'b0000;
        #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL wd_no_ack got %b want 0000", ack); end
        step();
        checks++; if (valid !== 1'b0 || gnt !== 4'b0000 || sel !== 2'd2) begin
            errors++; $display("FAIL wd_idle got valid=%b gnt=%b sel=%0d want 0 0000 2", valid, gnt, sel);
        end
        req = 4'b1111;
        step();
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL wd_ptr_kept got sel=%0d want 0", sel); end

        do_reset();
        req   = 4'b0100;
        ready = 1'b0;
        step();
        req   = 4'b0000;
        ready = 1'b1;
        #1;
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL wd_ready_ack got %b want 0100", ack); end
        step();
        req   = 4'b1111;
        ready = 1'b0;
        step();
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL wd_ready_ptr got sel=%0d want 3", sel); end
    endtask

`ifdef MUX_RR_LOCK_EN
    task automatic test_lock();
        do_reset();
        req   = 4'b1001;
        lock  = 1'b1;
        ready = 1'b0;
        step();
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lock = (k < 3);
            #1;
            checks++; if (valid !== 1'b1 || ack !== 4'b0001) begin
                errors++; $display("FAIL lock_ack%0d got valid=%b ack=%b want 1 0001", k, valid, ack);
            end
            step();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lock_release got valid=%b want 0", valid); end
        step();
        checks++; if (sel !== 2'd3 || gnt !== 4'b1000) begin
            errors++; $display("FAIL lock_next got sel=%0d gnt=%b want 3 1000", sel, gnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_stall();
        test_withdrawal();
`ifdef MUX_RR_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
